// File: rtl/uart_tx_if.sv
// Byte handoff between the UART store path (master) and the transmitter (slave).
// Carries the byte, its valid strobe and the transmitter's ready flag.
interface uart_tx_if;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_in_ready
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_in_ready
  );
endinterface

// File: rtl/uart_transmitter.sv
// Serializes accepted bytes onto serial_out as 8N1 frames: start bit, data bits LSB
// first, stop bit. Each symbol lasts SYMBOL_EDGE_TIME clocks.
// Optional feature: define UART_TX_PARITY_EN to insert one even-parity symbol after
// bit7, giving an 11-symbol frame.
module uart_transmitter #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave tx,
  output logic     serial_out
);

  localparam int unsigned SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] LastCount =
      CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e                         state_q, state_d;
  logic [CLOCK_COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]                     bit_q, bit_d;
  logic [7:0]                     shift_q, shift_d;
  logic                           serial_q, serial_d;
  logic                           ready_q, ready_d;
  logic                           symbol_done;
`ifdef UART_TX_PARITY_EN
  logic                           parity_q, parity_d;
`endif

  assign symbol_done      = (cnt_q == LastCount);
  assign tx.data_in_ready = ready_q;
  assign serial_out       = serial_q;

  // Next state; serial_d is the line level for the state being entered, so the
  // output flop changes on the same edge as the state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    serial_d = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (tx.data_in_valid && ready_q) begin
          state_d  = StStart;
          cnt_d    = '0;
          bit_d    = '0;
          shift_d  = tx.data_in;
          serial_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx.data_in;
`endif
        end
      end
      StStart: begin
        serial_d = 1'b0;
        if (symbol_done) begin
          state_d  = StData;
          cnt_d    = '0;
          serial_d = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        serial_d = shift_q[0];
        if (symbol_done) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d  = StParity;
            serial_d = parity_q;
`else
            state_d  = StStop;
            serial_d = 1'b1;
`endif
          end else begin
            bit_d    = bit_q + 3'd1;
            shift_d  = {1'b0, shift_q[7:1]};
            serial_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        serial_d = parity_q;
        if (symbol_done) begin
          state_d  = StStop;
          cnt_d    = '0;
          serial_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StStop: begin
        if (symbol_done) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    // Registered ready: high exactly in the cycles spent in idle.
    ready_d = (state_d == StIdle);
  end

  // State register with synchronous reset; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      ready_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serializes bytes handed off by the CPU's memory-mapped UART write path onto the `TX` pin as standard 8N1 asynchronous frames, with an optional parity bit. It sits directly downstream of the datapath's UART store logic, which drives its `data_in`/`data_in_valid` and samples `data_in_ready`. It is the transmit half of the `uart` instance and accepts one byte at a time through a ready/valid handshake.

## Interface
- `CLOCK_FREQ`, default 50_000_000: clk frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate in bits/s.
- Derived `SYMBOL_EDGE_TIME` = `CLOCK_FREQ / BAUD_RATE`, integer-truncated. Must be ≥ 2.
- Derived `CLOCK_COUNTER_WIDTH` = `$clog2(SYMBOL_EDGE_TIME)`.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_in`  in  8  byte to transmit.
- `data_in_valid`  in  1  producer has a byte on `data_in`.
- `data_in_ready`  out  1  transmitter can accept a byte this cycle.
- `serial_out`  out  1  TX line, idle high.

## Operation
- FSM states and transitions:
  - IDLE → START on handshake.
  - START → DATA after 1 symbol.
  - DATA → PARITY (if enabled) or STOP after 8 symbols.
  - PARITY → STOP after 1 symbol.
  - STOP → IDLE after 1 symbol.
- Handshake: a transfer occurs on a rising edge where `data_in_valid && data_in_ready`. `data_in` is latched into a shift register at that edge.
- `data_in_ready` is 1 only in IDLE and not in reset. It is a registered function of state, with no combinational path from `data_in_valid`.
- `data_in_valid` while not ready is ignored. The producer need not hold it.
- Changes on `data_in` after acceptance do not affect the frame in flight.
- Line levels per state:
  - START: `serial_out` = 0.
  - DATA: bits sent LSB first, bit0..bit7.
  - STOP: `serial_out` = 1.
  - IDLE: `serial_out` = 1.
- Symbol counter:
  - Counts 0..`SYMBOL_EDGE_TIME`-1, then wraps to 0 and advances the bit index.
  - The bit index is 0..7 in DATA.
  - The counter is cleared on entry to START.
- Reset:
  - While `rst` is high, `serial_out` = 1, `data_in_ready` = 0, state = IDLE, counters = 0.
  - Reset mid-frame aborts the frame. The line is high in the cycle after the reset edge, and no partial byte is resumed.
- Simultaneous events:
  - `rst` and a handshake on the same edge: reset wins and the byte is dropped.
  - `data_in_valid` high on the last STOP cycle is not accepted (ready=0). It is accepted on the next edge.

## Timing
- Let byte acceptance happen at edge k and N = `SYMBOL_EDGE_TIME`.
- Start bit: `serial_out` = 0 from cycle k+1 through k+N.
- Data bit i: cycles k+1+(i+1)·N through k+(i+2)·N.
- Stop bit: cycles k+1+9N through k+10N.
- `data_in_ready` = 1 at cycle k+1+10N. With parity, shift the stop bit and ready by +N.
- Back-to-back: if `data_in_valid` is held high, the next start bit begins at k+2+10N. There is exactly one idle-high cycle between frames.
- First cycle after `rst` deasserts: `data_in_ready` = 1.
- Output `serial_out` is driven from a flop, so it is glitch-free.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined: a PARITY state is inserted after bit7. It transmits even parity (XOR of the 8 data bits) for one symbol, giving an 11-symbol frame.
- Undefined: no PARITY state and no parity logic; 10-symbol 8N1 frame.
- The receiver side must be configured to match; this block does not check.

## Test plan
- Setup for all scenarios: `CLOCK_FREQ`=1000, `BAUD_RATE`=100 (N=10).
- Reset and idle:
  - Stimulus: hold `rst` 3 cycles, then release.
  - Required: `serial_out`=1 and `data_in_ready`=0 during reset; `data_in_ready`=1 on the first cycle after release.
- Single byte:
  - Stimulus: accept 0xA5 at edge k.
  - Required: line low over k+1..k+10, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, stop high; `data_in_ready` rises at k+101.
- Back-to-back:
  - Stimulus: hold valid high with 0x00, then 0xFF.
  - Required: second start bit at k+102; exactly one idle-high cycle between frames.
- Ignored input:
  - Stimulus: pulse valid with 0x3C mid-frame, and change `data_in` mid-frame.
  - Required: the frame in flight is unchanged, and 0x3C is never transmitted.
- Reset mid-frame:
  - Stimulus: assert `rst` during bit3 of 0x55.
  - Required: line high on the next cycle; after release, ready=1 and no residual bits are sent.
- Parity build:
  - Stimulus: with `UART_TX_PARITY_EN` defined, send 0x07.
  - Required: parity symbol = 1, stop bit at k+101..k+110, ready at k+111.
